layer_sequencer: RTL

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/layer_sequencer_pkg.sv | 32 +++
 rtl/layer_watchdog.sv | 42 ++++
 rtl/layer_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/layer_sequencer_pkg.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// layer_sequencer_pkg : shared FSM encoding and descriptor field layout
// Revision 1.0
//////////////////////////////////////////////////////////////////////////////
package layer_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_CFGWAIT = 3'd2,
      ST_LAUNCH  = 3'd3,
      ST_RUN     = 3'd4,
      ST_GAP     = 3'd5,
      ST_DONE    = 3'd6
   } state_t;

   localparam int DESC_W       = 12;
   localparam int DESC_DENSE   = 11;
   localparam int DESC_IN_MSB  = 10;
   localparam int DESC_IN_LSB  = 6;
   localparam int DESC_OUT_MSB = 5;
   localparam int DESC_OUT_LSB = 2;
   localparam int DESC_NOZERO  = 1;
   localparam int DESC_LAST    = 0;

   localparam int IN_W   = DESC_IN_MSB - DESC_IN_LSB + 1;
   localparam int OUT_W  = DESC_OUT_MSB - DESC_OUT_LSB + 1;
   localparam int WDOG_W = 16;

endpackage
`default_nettype wire

// File: rtl/layer_watchdog.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// layer_watchdog : per-layer cycle counter, flags when a layer overruns
// Revision 1.0
//////////////////////////////////////////////////////////////////////////////
module layer_watchdog
   import layer_sequencer_pkg::*;
#(
   parameter int TIMEOUT = 65535
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expired
);

   logic [WDOG_W-1:0] count_q;
   logic [WDOG_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (run && (count_q != {WDOG_W{1'b1}})) begin
         count_d = count_q + WDOG_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Fires on the TIMEOUT-th RUN cycle so the enable is high exactly TIMEOUT cycles.
   assign expired = run && (count_q == WDOG_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
//////////////////////////////////////////////////////////////////////////////
// layer_sequencer : walks the layer descriptor table, launching one engine per layer
// Revision 1.0
//////////////////////////////////////////////////////////////////////////////
module layer_sequencer
   import layer_sequencer_pkg::*;
#(
   parameter int SIZE_address_pix = 13,
   parameter int BUF_A             = 0,
   parameter int BUF_B             = 4096,
   parameter int MAX_LAYERS        = 16,
   parameter int TIMEOUT           = 65535
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   output logic [$clog2(MAX_LAYERS)-1:0] cfg_addr,
   input  logic [DESC_W-1:0]             cfg_data,
   output logic                          conv_en,
   output logic                          dense_en,
   input  logic                          conv_stop,
   input  logic                          dense_stop,
   output logic [SIZE_address_pix-1:0]   memstartp,
   output logic [SIZE_address_pix-1:0]   memstartzap,
   output logic [IN_W-1:0]               in,
   output logic [OUT_W-1:0]              out,
   output logic [IN_W-1:0]               in_dense,
   output logic                          nozero,
   output logic                          busy,
   output logic                          done,
   output logic                          timeout_err
);

   localparam int AW = $clog2(MAX_LAYERS);
   localparam logic [SIZE_address_pix-1:0] BASE_A   = SIZE_address_pix'(BUF_A);
   localparam logic [SIZE_address_pix-1:0] BASE_B   = SIZE_address_pix'(BUF_B);
   localparam logic [AW-1:0]               LAST_IDX = AW'(MAX_LAYERS - 1);

   state_t                      state_q, state_d;
   logic [AW-1:0]               idx_q, idx_d;
   logic                        toggle_q, toggle_d;
   logic                        gap_q, gap_d;
   logic                        is_dense_q, is_dense_d;
   logic                        last_q, last_d;
   logic                        conv_en_q, conv_en_d;
   logic                        dense_en_q, dense_en_d;
   logic [SIZE_address_pix-1:0] memstartp_q, memstartp_d;
   logic [SIZE_address_pix-1:0] memstartzap_q, memstartzap_d;
   logic [IN_W-1:0]             in_q, in_d;
   logic [OUT_W-1:0]            out_q, out_d;
   logic [IN_W-1:0]             in_dense_q, in_dense_d;
   logic                        nozero_q, nozero_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic                        timeout_err_q, timeout_err_d;

   logic active_stop;
   logic wd_clear;
   logic wd_run;
   logic wd_expired;

   layer_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear),
      .run     (wd_run),
      .expired (wd_expired)
   );

   // Only the engine that was launched may end the layer.
   assign active_stop = is_dense_q ? dense_stop : conv_stop;

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      toggle_d      = toggle_q;
      gap_d         = gap_q;
      is_dense_d    = is_dense_q;
      last_d        = last_q;
      conv_en_d     = conv_en_q;
      dense_en_d    = dense_en_q;
      memstartp_d   = memstartp_q;
      memstartzap_d = memstartzap_q;
      in_d          = in_q;
      out_d         = out_q;
      in_dense_d    = in_dense_q;
      nozero_d      = nozero_q;
      done_d        = 1'b0;
      timeout_err_d = timeout_err_q;
      wd_clear      = 1'b0;
      wd_run        = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d       = ST_FETCH;
               idx_d         = '0;
               toggle_d      = 1'b0;
               timeout_err_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: begin
            state_d = ST_CFGWAIT;
         end
         ST_CFGWAIT: begin
            is_dense_d    = cfg_data[DESC_DENSE];
            last_d        = cfg_data[DESC_LAST];
            in_d          = cfg_data[DESC_IN_MSB:DESC_IN_LSB];
            out_d         = cfg_data[DESC_OUT_MSB:DESC_OUT_LSB];
            nozero_d      = cfg_data[DESC_NOZERO];
            in_dense_d    = cfg_data[DESC_DENSE] ? cfg_data[DESC_IN_MSB:DESC_IN_LSB] : '0;
            memstartp_d   = toggle_q ? BASE_B : BASE_A;
            memstartzap_d = toggle_q ? BASE_A : BASE_B;
            state_d       = ST_LAUNCH;
         end
         ST_LAUNCH: begin
            wd_clear   = 1'b1;
            conv_en_d  = ~is_dense_q;
            dense_en_d = is_dense_q;
            state_d    = ST_RUN;
         end
         ST_RUN: begin
            wd_run = 1'b1;
            if (active_stop) begin
               // Swap bases so memstartp always names the buffer just written.
               conv_en_d     = 1'b0;
               dense_en_d    = 1'b0;
               toggle_d      = ~toggle_q;
               memstartp_d   = memstartzap_q;
               memstartzap_d = memstartp_q;
               gap_d         = 1'b0;
               state_d       = ST_GAP;
            end else if (wd_expired) begin
               conv_en_d     = 1'b0;
               dense_en_d    = 1'b0;
               timeout_err_d = 1'b1;
               state_d       = ST_IDLE;
            end
         end
         ST_GAP: begin
            // Two idle cycles give the engine time to clear before the next fetch.
            if (!gap_q) begin
               gap_d = 1'b1;
            end else begin
               gap_d = 1'b0;
               if (last_q || (idx_q == LAST_IDX)) begin
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + AW'(1);
                  state_d = ST_FETCH;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         toggle_q      <= 1'b0;
         gap_q         <= 1'b0;
         is_dense_q    <= 1'b0;
         last_q        <= 1'b0;
         conv_en_q     <= 1'b0;
         dense_en_q    <= 1'b0;
         memstartp_q   <= '0;
         memstartzap_q <= '0;
         in_q          <= '0;
         out_q         <= '0;
         in_dense_q    <= '0;
         nozero_q      <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         toggle_q      <= toggle_d;
         gap_q         <= gap_d;
         is_dense_q    <= is_dense_d;
         last_q        <= last_d;
         conv_en_q     <= conv_en_d;
         dense_en_q    <= dense_en_d;
         memstartp_q   <= memstartp_d;
         memstartzap_q <= memstartzap_d;
         in_q          <= in_d;
         out_q         <= out_d;
         in_dense_q    <= in_dense_d;
         nozero_q      <= nozero_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign cfg_addr    = idx_q;
   assign conv_en     = conv_en_q;
   assign dense_en    = dense_en_q;
   assign memstartp   = memstartp_q;
   assign memstartzap = memstartzap_q;
   assign in          = in_q;
   assign out         = out_q;
   assign in_dense    = in_dense_q;
   assign nozero      = nozero_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire
